dma_mc_sequencer: RTL and testbench

Parametrised multi-channel descriptor DMA sequencer. It is the successor to the single-channel descriptor register block. Each of NUM_CH channels holds its own descriptor: source, destination, length, next-descriptor address and end-of-chain flag. The block splits each channel's transfer into bursts of at most 2^LEN_W beats, arbitrates channels round-robin onto a single burst-engine port, and raises per-channel sticky interrupts. It sits between the CPU-side configuration slave and the AXI burst master.

---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_rr_arbiter.sv | 41 ++++
 rtl/dma_mc_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_dma_mc_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared encodings for the multi-channel DMA sequencer.
package dma_pkg;

    // Field select codes for configuration writes
    typedef enum logic [2:0] {
        SEL_SRC   = 3'd1,
        SEL_DST   = 3'd2,
        SEL_LEN   = 3'd3,
        SEL_NEXT  = 3'd4,
        SEL_EOC   = 3'd5,
        SEL_START = 3'd6
    } cfg_sel_e;

    // Per-channel state
    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_READY  = 2'd1,
        CH_ACTIVE = 2'd2,
        CH_CHAIN  = 2'd3
    } ch_state_e;

    // Global burst sequencer state
    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_REQ  = 2'd1,
        G_WAIT = 2'd2
    } g_state_e;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel.
// The pointer only moves when a grant is actually taken (i_adv high).
module dma_rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_adv,
    output logic              o_gnt_valid,
    output logic [CH_W-1:0]   o_gnt_idx
);

    logic [CH_W-1:0] r_ptr;

    // Pick the first requester after r_ptr; iterating downwards lets the nearest one win
    always_comb begin : p_gnt
        int unsigned v_idx;
        v_idx       = 0;
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            v_idx = (32'(r_ptr) + k) % NUM_CH;
            if (i_req[v_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = CH_W'(v_idx);
            end
        end
    end

    // Last-grant pointer; resets to the top channel so channel 0 is searched first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= CH_W'(NUM_CH - 1);
        end else if (i_adv && o_gnt_valid) begin
            r_ptr <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/dma_mc_sequencer.sv
// Multi-channel descriptor DMA sequencer: splits each channel's transfer into
// bursts of up to 2^LEN_W beats, round-robins them onto one burst port, and
// raises sticky per-channel interrupts. Define DMA_ABORT_EN to add ch_abort.
module dma_mc_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [2:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [NUM_CH-1:0] ch_busy,
    output logic              bst_valid,
    input  logic              bst_ready,
    output logic [CH_W-1:0]   bst_ch,
    output logic [ADDR_W-1:0] bst_src,
    output logic [ADDR_W-1:0] bst_dst,
    output logic [LEN_W-1:0]  bst_len,
    input  logic              bst_done,
    output logic              chain_valid,
    output logic [CH_W-1:0]   chain_ch,
    output logic [ADDR_W-1:0] chain_addr,
    input  logic              chain_ready,
    output logic [NUM_CH-1:0] irq,
    input  logic [NUM_CH-1:0] irq_clr
`ifdef DMA_ABORT_EN
    ,
    input  logic [NUM_CH-1:0] ch_abort
`endif
);

    localparam int unsigned      BYTES     = DATA_W / 8;
    localparam logic [DATA_W-1:0] MAX_BEATS = DATA_W'(2 ** LEN_W);

    ch_state_e         r_st      [NUM_CH];
    logic [ADDR_W-1:0] r_src     [NUM_CH];
    logic [ADDR_W-1:0] r_dst     [NUM_CH];
    logic [ADDR_W-1:0] r_next    [NUM_CH];
    logic [ADDR_W-1:0] r_cur_src [NUM_CH];
    logic [ADDR_W-1:0] r_cur_dst [NUM_CH];
    logic [DATA_W-1:0] r_len     [NUM_CH];
    logic [DATA_W-1:0] r_rem     [NUM_CH];
    logic [NUM_CH-1:0] r_eoc;
    logic [NUM_CH-1:0] r_irq;

    g_state_e          r_gst;
    logic [CH_W-1:0]   r_gch;
    logic              r_bst_valid;
    logic [ADDR_W-1:0] r_bst_src;
    logic [ADDR_W-1:0] r_bst_dst;
    logic [LEN_W-1:0]  r_bst_len;
    logic [DATA_W-1:0] r_beats;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_abort_in;
    logic [NUM_CH-1:0] w_abort_pend;
    logic              w_gnt_valid;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [DATA_W-1:0] w_gnt_beats;
    logic [DATA_W-1:0] w_rem_new;
    logic [ADDR_W-1:0] w_incr;
    logic              w_chain_valid;
    logic [CH_W-1:0]   w_chain_ch;

`ifdef DMA_ABORT_EN
    logic [NUM_CH-1:0] r_abort;

    assign w_abort_in   = ch_abort;
    assign w_abort_pend = r_abort;

    // Remember an abort aimed at the active channel until its burst retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abort <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (r_st[i] != CH_ACTIVE) r_abort[i] <= 1'b0;
                else if (ch_abort[i])     r_abort[i] <= 1'b1;
            end
        end
    end
`else
    assign w_abort_in   = '0;
    assign w_abort_pend = '0;
`endif

    // Request vector, busy flags; an abort this cycle masks the request
    always_comb begin
        w_req   = '0;
        ch_busy = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_req[i]   = (r_st[i] == CH_READY) && !w_abort_in[i];
            ch_busy[i] = (r_st[i] != CH_IDLE);
        end
    end

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_req),
        .i_adv       ((r_gst == G_IDLE) && en),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Burst sizing and post-burst bookkeeping
    always_comb begin
        w_gnt_beats = (r_rem[w_gnt_idx] > MAX_BEATS) ? MAX_BEATS : r_rem[w_gnt_idx];
        w_rem_new   = r_rem[r_gch] - r_beats;
        w_incr      = ADDR_W'(r_beats * BYTES);
    end

    // Lowest-index channel waiting for a descriptor fetch
    always_comb begin
        w_chain_valid = 1'b0;
        w_chain_ch    = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (r_st[i] == CH_CHAIN) begin
                w_chain_valid = 1'b1;
                w_chain_ch    = CH_W'(i);
            end
        end
    end

    // Channel descriptors, channel states, burst sequencer and interrupts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_st[i]      <= CH_IDLE;
                r_src[i]     <= '0;
                r_dst[i]     <= '0;
                r_next[i]    <= '0;
                r_cur_src[i] <= '0;
                r_cur_dst[i] <= '0;
                r_len[i]     <= '0;
                r_rem[i]     <= '0;
            end
            r_eoc       <= '0;
            r_irq       <= '0;
            r_gst       <= G_IDLE;
            r_gch       <= '0;
            r_bst_valid <= 1'b0;
            r_bst_src   <= '0;
            r_bst_dst   <= '0;
            r_bst_len   <= '0;
            r_beats     <= '0;
        end else begin
            // Clear first so a same-cycle set below overrides it
            r_irq <= r_irq & ~irq_clr;

            for (int i = 0; i < int'(NUM_CH); i++) begin
                case (r_st[i])
                    CH_IDLE: begin
                        if (cfg_we && cfg_ch == CH_W'(i)) begin
                            case (cfg_sel_e'(cfg_sel))
                                SEL_SRC:  r_src[i]  <= ADDR_W'(cfg_wdata);
                                SEL_DST:  r_dst[i]  <= ADDR_W'(cfg_wdata);
                                SEL_LEN:  r_len[i]  <= cfg_wdata;
                                SEL_NEXT: r_next[i] <= ADDR_W'(cfg_wdata);
                                SEL_EOC:  r_eoc[i]  <= cfg_wdata[0];
                                SEL_START: begin
                                    if (r_len[i] == '0) begin
                                        // Empty transfer takes the completion path directly
                                        if (r_eoc[i]) r_irq[i] <= 1'b1;
                                        else          r_st[i]  <= CH_CHAIN;
                                    end else begin
                                        r_st[i]      <= CH_READY;
                                        r_cur_src[i] <= r_src[i];
                                        r_cur_dst[i] <= r_dst[i];
                                        r_rem[i]     <= r_len[i];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    CH_READY, CH_CHAIN: begin
                        if (w_abort_in[i]) r_st[i] <= CH_IDLE;
                    end
                    default: ;
                endcase
            end

            if (w_chain_valid && chain_ready) r_st[w_chain_ch] <= CH_IDLE;

            case (r_gst)
                G_IDLE: begin
                    if (en && w_gnt_valid) begin
                        r_st[w_gnt_idx] <= CH_ACTIVE;
                        r_gch           <= w_gnt_idx;
                        r_beats         <= w_gnt_beats;
                        r_bst_valid     <= 1'b1;
                        r_bst_src       <= r_cur_src[w_gnt_idx];
                        r_bst_dst       <= r_cur_dst[w_gnt_idx];
                        r_bst_len       <= LEN_W'(w_gnt_beats - 1'b1);
                        r_gst           <= G_REQ;
                    end
                end
                G_REQ: begin
                    if (bst_ready) begin
                        r_bst_valid <= 1'b0;
                        r_gst       <= G_WAIT;
                    end
                end
                G_WAIT: begin
                    if (bst_done) begin
                        r_cur_src[r_gch] <= r_cur_src[r_gch] + w_incr;
                        r_cur_dst[r_gch] <= r_cur_dst[r_gch] + w_incr;
                        r_rem[r_gch]     <= w_rem_new;
                        if (w_abort_pend[r_gch] || w_abort_in[r_gch]) begin
                            r_st[r_gch] <= CH_IDLE;
                        end else if (w_rem_new != '0) begin
                            r_st[r_gch] <= CH_READY;
                        end else if (r_eoc[r_gch]) begin
                            r_st[r_gch]  <= CH_IDLE;
                            r_irq[r_gch] <= 1'b1;
                        end else begin
                            r_st[r_gch] <= CH_CHAIN;
                        end
                        r_gst <= G_IDLE;
                    end
                end
                default: r_gst <= G_IDLE;
            endcase
        end
    end

    assign bst_valid   = r_bst_valid;
    assign bst_ch      = r_gch;
    assign bst_src     = r_bst_src;
    assign bst_dst     = r_bst_dst;
    assign bst_len     = r_bst_len;
    assign chain_valid = w_chain_valid;
    assign chain_ch    = w_chain_ch;
    assign chain_addr  = r_next[w_chain_ch];
    assign irq         = r_irq;

endmodule

// File: tb/tb_dma_mc_sequencer.sv
// Directed bench for dma_mc_sequencer (default 2 channels, 32-bit, LEN_W=4).
module tb_dma_mc_sequencer;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_wdata;
    logic [1:0]  ch_busy;
    logic        bst_valid;
    logic        bst_ready;
    logic [0:0]  bst_ch;
    logic [31:0] bst_src;
    logic [31:0] bst_dst;
    logic [3:0]  bst_len;
    logic        bst_done;
    logic        chain_valid;
    logic [0:0]  chain_ch;
    logic [31:0] chain_addr;
    logic        chain_ready;
    logic [1:0]  irq;
    logic [1:0]  irq_clr;
`ifdef DMA_ABORT_EN
    logic [1:0]  ch_abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_mc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_wdata   (cfg_wdata),
        .ch_busy     (ch_busy),
        .bst_valid   (bst_valid),
        .bst_ready   (bst_ready),
        .bst_ch      (bst_ch),
        .bst_src     (bst_src),
        .bst_dst     (bst_dst),
        .bst_len     (bst_len),
        .bst_done    (bst_done),
        .chain_valid (chain_valid),
        .chain_ch    (chain_ch),
        .chain_addr  (chain_addr),
        .chain_ready (chain_ready),
        .irq         (irq),
        .irq_clr     (irq_clr)
`ifdef DMA_ABORT_EN
        ,
        .ch_abort    (ch_abort)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [0:0] ch, input logic [2:0] sel, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Wait for a burst request, check it, accept it and return bst_done
    task automatic serve_burst(input logic [0:0] ch, input logic [31:0] src, input logic [31:0] dst,
                               input logic [3:0] len, input int exp_wait, input string tag);
        int w = 0;
        while (bst_valid !== 1'b1 && w < 40) begin step(); w++; end
        n_vec++; if (bst_valid !== 1'b1) begin n_err++; $display("FAIL %s valid: got %b want 1 (timeout)", tag, bst_valid); end
        n_vec++; if (bst_ch !== ch) begin n_err++; $display("FAIL %s ch: got %0d want %0d", tag, bst_ch, ch); end
        n_vec++; if (bst_src !== src) begin n_err++; $display("FAIL %s src: got %h want %h", tag, bst_src, src); end
        n_vec++; if (bst_dst !== dst) begin n_err++; $display("FAIL %s dst: got %h want %h", tag, bst_dst, dst); end
        n_vec++; if (bst_len !== len) begin n_err++; $display("FAIL %s len: got %0d want %0d", tag, bst_len, len); end
        if (exp_wait >= 0) begin
            n_vec++; if (w != exp_wait) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, w, exp_wait); end
        end
        step();
        n_vec++; if (bst_valid !== 1'b0) begin n_err++; $display("FAIL %s valid drop: got %b want 0", tag, bst_valid); end
        bst_done = 1'b1;
        step();
        bst_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
        bst_ready = 1'b1; bst_done = 1'b0; chain_ready = 1'b0; irq_clr = '0;
`ifdef DMA_ABORT_EN
        ch_abort = '0;
`endif
        step(); step();
        n_vec++; if (bst_valid !== 1'b0) begin n_err++; $display("FAIL rst bst_valid: got %b want 0", bst_valid); end
        n_vec++; if (ch_busy !== 2'b00) begin n_err++; $display("FAIL rst ch_busy: got %b want 00", ch_busy); end
        n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL rst irq: got %b want 00", irq); end
        n_vec++; if (chain_valid !== 1'b0) begin n_err++; $display("FAIL rst chain_valid: got %b want 0", chain_valid); end
        n_vec++; if (bst_src !== 32'h0 || bst_len !== 4'h0) begin n_err++; $display("FAIL rst bst fields: got %h/%0d want 0/0", bst_src, bst_len); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_channel();
        cfg_write(1'b0, SEL_SRC, 32'h1000);
        cfg_write(1'b0, SEL_DST, 32'h2000);
        cfg_write(1'b0, SEL_LEN, 32'd40);
        cfg_write(1'b0, SEL_EOC, 32'd1);
        cfg_write(1'b0, SEL_START, 32'd0);
        n_vec++; if (ch_busy !== 2'b01) begin n_err++; $display("FAIL single busy: got %b want 01", ch_busy); end
        serve_burst(1'b0, 32'h1000, 32'h2000, 4'd15, 1, "single b0");
        n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL single early irq: got %b want 00", irq); end
        serve_burst(1'b0, 32'h1040, 32'h2040, 4'd15, 1, "single b1");
        serve_burst(1'b0, 32'h1080, 32'h2080, 4'd7, 1, "single b2");
        n_vec++; if (irq !== 2'b01) begin n_err++; $display("FAIL single irq: got %b want 01", irq); end
        n_vec++; if (ch_busy !== 2'b00) begin n_err++; $display("FAIL single idle: got %b want 00", ch_busy); end
        irq_clr = 2'b01; step(); irq_clr = 2'b00;
        n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL single irq_clr: got %b want 00", irq); end
    endtask

    task automatic test_round_robin();
        cfg_write(1'b0, SEL_SRC, 32'h4000);
        cfg_write(1'b0, SEL_DST, 32'h5000);
        cfg_write(1'b0, SEL_LEN, 32'd20);
        cfg_write(1'b1, SEL_SRC, 32'h6000);
        cfg_write(1'b1, SEL_DST, 32'h7000);
        cfg_write(1'b1, SEL_LEN, 32'd20);
        cfg_write(1'b1, SEL_EOC, 32'd1);
        cfg_write(1'b0, SEL_START, 32'd0);
        cfg_write(1'b1, SEL_START, 32'd0);
        serve_burst(1'b0, 32'h4000, 32'h5000, 4'd15, -1, "rr g0");
        serve_burst(1'b1, 32'h6000, 32'h7000, 4'd15, 1, "rr g1");
        serve_burst(1'b0, 32'h4040, 32'h5040, 4'd3, 1, "rr g2");
        serve_burst(1'b1, 32'h6040, 32'h7040, 4'd3, 1, "rr g3");
        n_vec++; if (irq !== 2'b11) begin n_err++; $display("FAIL rr irq: got %b want 11", irq); end
        irq_clr = 2'b11; step(); irq_clr = 2'b00;
        n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL rr irq_clr: got %b want 00", irq); end
    endtask

    task automatic test_chain();
        cfg_write(1'b1, SEL_SRC, 32'h8000);
        cfg_write(1'b1, SEL_DST, 32'h9000);
        cfg_write(1'b1, SEL_LEN, 32'd4);
        cfg_write(1'b1, SEL_NEXT, 32'h3000);
        cfg_write(1'b1, SEL_EOC, 32'd0);
        cfg_write(1'b1, SEL_START, 32'd0);
        serve_burst(1'b1, 32'h8000, 32'h9000, 4'd3, 1, "chain burst");
        n_vec++; if (chain_valid !== 1'b1) begin n_err++; $display("FAIL chain valid: got %b want 1", chain_valid); end
        n_vec++; if (chain_ch !== 1'b1) begin n_err++; $display("FAIL chain ch: got %0d want 1", chain_ch); end
        n_vec++; if (chain_addr !== 32'h3000) begin n_err++; $display("FAIL chain addr: got %h want 3000", chain_addr); end
        n_vec++; if (ch_busy !== 2'b10) begin n_err++; $display("FAIL chain busy: got %b want 10", ch_busy); end
        chain_ready = 1'b1; step(); chain_ready = 1'b0;
        n_vec++; if (ch_busy !== 2'b00) begin n_err++; $display("FAIL chain done busy: got %b want 00", ch_busy); end
        n_vec++; if (chain_valid !== 1'b0) begin n_err++; $display("FAIL chain done valid: got %b want 0", chain_valid); end
        n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL chain irq: got %b want 00", irq); end
    endtask

    task automatic test_zero_len();
        logic quiet = 1'b1;
        cfg_write(1'b0, SEL_LEN, 32'd0);
        cfg_write(1'b0, SEL_START, 32'd0);
        n_vec++; if (irq !== 2'b01) begin n_err++; $display("FAIL zlen irq: got %b want 01", irq); end
        n_vec++; if (ch_busy !== 2'b00) begin n_err++; $display("FAIL zlen busy: got %b want 00", ch_busy); end
        repeat (3) begin
            if (bst_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL zlen no burst: got %b want 1", quiet); end
        irq_clr = 2'b01; step(); irq_clr = 2'b00;
    endtask

    task automatic test_enable_and_ignored_write();
        logic quiet = 1'b1;
        en = 1'b0; bst_ready = 1'b0;
        cfg_write(1'b0, SEL_SRC, 32'hA000);
        cfg_write(1'b0, SEL_DST, 32'hB000);
        cfg_write(1'b0, SEL_LEN, 32'd8);
        cfg_write(1'b0, SEL_START, 32'd0);
        repeat (4) begin
            if (bst_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL en gate: got %b want 1", quiet); end
        n_vec++; if (ch_busy !== 2'b01) begin n_err++; $display("FAIL en busy: got %b want 01", ch_busy); end
        en = 1'b1;
        step();
        n_vec++; if (bst_valid !== 1'b1) begin n_err++; $display("FAIL en rise: got %b want 1", bst_valid); end
        cfg_write(1'b0, SEL_SRC, 32'hDEAD0000);
        n_vec++; if (bst_valid !== 1'b1 || bst_src !== 32'hA000) begin n_err++; $display("FAIL en hold: got %b/%h want 1/a000", bst_valid, bst_src); end
        bst_ready = 1'b1;
        step();
        n_vec++; if (bst_valid !== 1'b0) begin n_err++; $display("FAIL en accept: got %b want 0", bst_valid); end
        bst_done = 1'b1; step(); bst_done = 1'b0;
        n_vec++; if (irq !== 2'b01) begin n_err++; $display("FAIL en irq: got %b want 01", irq); end
        irq_clr = 2'b01; step(); irq_clr = 2'b00;
        cfg_write(1'b0, SEL_START, 32'd0);
        serve_burst(1'b0, 32'hA000, 32'hB000, 4'd7, 1, "ignored src");
        irq_clr = 2'b01; step(); irq_clr = 2'b00;
    endtask

`ifdef DMA_ABORT_EN
    task automatic test_abort();
        logic quiet = 1'b1;
        cfg_write(1'b0, SEL_SRC, 32'hC000);
        cfg_write(1'b0, SEL_LEN, 32'd40);
        cfg_write(1'b0, SEL_START, 32'd0);
        step();
        n_vec++; if (bst_valid !== 1'b1) begin n_err++; $display("FAIL abort req: got %b want 1", bst_valid); end
        step();
        ch_abort = 2'b01; step(); ch_abort = 2'b00;
        n_vec++; if (ch_busy !== 2'b01) begin n_err++; $display("FAIL abort inflight: got %b want 01", ch_busy); end
        bst_done = 1'b1; step(); bst_done = 1'b0;
        n_vec++; if (ch_busy !== 2'b00) begin n_err++; $display("FAIL abort idle: got %b want 00", ch_busy); end
        n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL abort irq: got %b want 00", irq); end
        repeat (4) begin
            if (bst_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        n_vec++; if (quiet !== 1'b1) begin n_err++; $display("FAIL abort no burst: got %b want 1", quiet); end
    endtask
`endif

    task automatic test_reset_midburst();
        cfg_write(1'b0, SEL_LEN, 32'd40);
        cfg_write(1'b0, SEL_START, 32'd0);
        step();
        n_vec++; if (bst_valid !== 1'b1) begin n_err++; $display("FAIL midrst req: got %b want 1", bst_valid); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bst_valid !== 1'b0 || ch_busy !== 2'b00) begin n_err++; $display("FAIL midrst async: got %b/%b want 0/00", bst_valid, ch_busy); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_chain();
        test_zero_len();
        test_enable_and_ignored_write();
`ifdef DMA_ABORT_EN
        test_abort();
`endif
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
